sig_word_serializer: RTL and testbench
======================================

# sig_word_serializer

Transmit-side streaming engine for ECDSA results. It accepts one `signature_t` (r, s) per handshake and range-checks both halves against the secp256k1 group order `params.n`. Valid signatures are emitted as a big-endian stream of WORD_W-bit words with first/last markers; invalid ones are dropped and an error pulse is raised. It sits between the signing core and the host/bus word interface, on the transmit end of the signature path.

## Interface
Parameters:
- WORD_W, 32, output word width; legal values 8, 16, 32, 64, 128, 256. Derived NW = 512/WORD_W words per signature.
- CHECK_RANGE, 1, 1 = enforce 1 ≤ r,s ≤ n−1; 0 = forward everything.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- sig_valid  in  1  input signature present
- sig_ready  out  1  block can accept a signature
- sig  in  512  `signature_t` from `elliptic_curve_structs`; r = sig[511:256], s = sig[255:0]
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts word
- out_data  out  WORD_W  current word
- out_first  out  1  current word is word 0 (MS word of r)
- out_last  out  1  current word is word NW−1 (LS word of s)
- err_valid  out  1  one-cycle pulse: signature rejected
- err_code  out  2  bit0 = r out of range, bit1 = s out of range; held until next rejection

## Operation
- States: IDLE, REJECT, SEND.
- IDLE: sig_ready=1, out_valid=0. On sig_valid&sig_ready:
  - capture sig into a 512-bit shift register (sreg);
  - register range flags computed combinationally from the input;
  - clear the word counter cnt.
  - Next state is REJECT if any flag is set and CHECK_RANGE=1, else SEND.
- Range rule: a value v is bad iff v==0 or v ≥ n (unsigned 256-bit compare, n = FFFF…FFFE BAAEDCE6 AF48A03B BFD25E8C D0364141).
- REJECT (1 cycle):
  - err_valid=1 and err_code=flags;
  - no output words;
  - next state IDLE.
- SEND:
  - Outputs: out_valid=1, out_data=sreg[511 -: WORD_W], out_first=(cnt==0), out_last=(cnt==NW−1).
  - On out_valid&out_ready: sreg shifts left by WORD_W; cnt increments.
  - If out_last, next state is IDLE and cnt returns to 0.
  - Without out_ready, out_data, out_first and out_last are held stable.
- sig_ready=0 in REJECT and SEND; input is never accepted mid-stream.
- cnt width is ceil(log2(NW)), minimum 1 bit. NW=1 when WORD_W=512 is not legal.

## Timing
- Reset (async assert, sync deassert by system):
  - state=IDLE; sig_ready=1; out_valid=0, out_first=0, out_last=0;
  - out_data=0; err_valid=0, err_code=0; sreg=0; cnt=0.
- Reset mid-SEND aborts the stream immediately. No out_last is issued, and no partial state survives.
- Input handshake at edge t: out_valid=1 with word 0 from edge t+1, or err_valid=1 for cycle t+1 only.
- With out_ready held high, the stream occupies NW consecutive cycles. sig_ready returns high the cycle after the last beat.
- Minimum period: NW+1 cycles per accepted signature; 2 cycles per rejected one.
- out_valid never drops without a completed handshake (AXI-stream style). out_valid does not depend combinationally on out_ready.
- err_code updates only in the REJECT cycle.

## Test plan
- r=1, s=2, WORD_W=32, out_ready=1 → 16 words in 16 consecutive cycles:
  - 7×0, 0x00000001, 7×0, 0x00000002;
  - out_first on beat 0, out_last on beat 15; sig_ready=0 throughout, 1 afterwards.
- r=n−1, s=n−1 with random out_ready backpressure (~50%) → accepted. Words FFFFFFFF…D0364140 twice, in order. out_data stable while stalled. No err_valid.
- r=0, s=5 → err_valid pulse one cycle after handshake, err_code=01, no out_valid. Then s=n, r=3 → err_code=10. Then r=s=n → err_code=11.
- CHECK_RANGE=0, r=0, s=n → streamed unchanged, 16 words, no err_valid.
- rst_n asserted low after beat 5 of a stream → all outputs reach reset values asynchronously. After release, a new signature r=0xA, s=0xB streams from word 0 with out_first=1.
- WORD_W=8, r=0x0102…20 pattern → 64 beats, MSB byte first, out_last on beat 63 only.

Source files
------------

// File: rtl/sig_word_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sig_word_serializer: range-checks an ECDSA (r,s) pair against the secp256k1 |
// | order and streams accepted pairs MS word first.   Revision: 1.0             |
// +----------------------------------------------------------------------------+
module sig_word_serializer #(
   parameter int WORD_W      = 32,
   parameter bit CHECK_RANGE = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_sig_valid,
   output logic              o_sig_ready,
   input  logic [511:0]      i_sig,
   output logic              o_out_valid,
   input  logic              i_out_ready,
   output logic [WORD_W-1:0] o_out_data,
   output logic              o_out_first,
   output logic              o_out_last,
   output logic              o_err_valid,
   output logic [1:0]        o_err_code
);

   localparam int c_NW    = 512 / WORD_W;
   localparam int c_CNT_W = (c_NW > 1) ? $clog2(c_NW) : 1;
   localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(c_NW - 1);
   localparam logic [255:0] c_N =
      256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_BAAEDCE6_AF48A03B_BFD25E8C_D0364141;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_REJECT = 2'd1,
      ST_SEND   = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_next;
   logic [511:0]         r_sreg;
   logic [c_CNT_W-1:0]   r_cnt;
   logic [1:0]           r_err_code;

   logic                 w_r_bad;
   logic                 w_s_bad;
   logic [1:0]           w_flags;
   logic                 w_reject;
   logic                 w_accept;
   logic                 w_beat;
   logic                 w_last;

   // A half is bad when it is zero or not below the group order.
   assign w_r_bad  = (i_sig[511:256] == 256'd0) || (i_sig[511:256] >= c_N);
   assign w_s_bad  = (i_sig[255:0]   == 256'd0) || (i_sig[255:0]   >= c_N);
   assign w_flags  = {w_s_bad, w_r_bad};
   assign w_reject = CHECK_RANGE && (w_flags != 2'b00);

   assign w_accept = i_sig_valid && (r_state == ST_IDLE);
   assign w_last   = (r_cnt == c_LAST);
   assign w_beat   = (r_state == ST_SEND) && i_out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next      = r_state;
      o_sig_ready = 1'b0;
      o_out_valid = 1'b0;
      o_err_valid = 1'b0;
      case (r_state)
         ST_IDLE: begin
            o_sig_ready = 1'b1;
            if (i_sig_valid) begin
               w_next = w_reject ? ST_REJECT : ST_SEND;
            end
         end
         ST_REJECT: begin
            o_err_valid = 1'b1;
            w_next      = ST_IDLE;
         end
         ST_SEND: begin
            o_out_valid = 1'b1;
            if (i_out_ready && w_last) begin
               w_next = ST_IDLE;
            end
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
   end

   // err_code is loaded on the accepting edge so it is already valid in the REJECT cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sreg     <= 512'd0;
         r_cnt      <= '0;
         r_err_code <= 2'b00;
      end else if (w_accept) begin
         r_sreg <= i_sig;
         r_cnt  <= '0;
         if (w_reject) begin
            r_err_code <= w_flags;
         end
      end else if (w_beat) begin
         r_sreg <= {r_sreg[511-WORD_W:0], {WORD_W{1'b0}}};
         r_cnt  <= w_last ? '0 : r_cnt + 1'b1;
      end
   end

   assign o_out_data  = (r_state == ST_SEND) ? r_sreg[511 -: WORD_W] : '0;
   assign o_out_first = (r_state == ST_SEND) && (r_cnt == '0);
   assign o_out_last  = (r_state == ST_SEND) && w_last;
   assign o_err_code  = r_err_code;

endmodule
`default_nettype wire

// File: tb/tb_sig_word_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_sig_word_serializer: randomized bench against a word-list model for three|
// | configurations (32/range, 32/no-range, 8/range).   Revision: 1.0            |
// +----------------------------------------------------------------------------+
module tb_sig_word_serializer;

   localparam logic [255:0] c_N =
      256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_BAAEDCE6_AF48A03B_BFD25E8C_D0364141;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         sig_valid = 1'b0;
   logic [511:0] sig = '0;
   logic         out_ready = 1'b0;
   int           sel = 0;

   int n_total = 0;
   int n_bad   = 0;

   logic        a_sig_ready, a_out_valid, a_out_first, a_out_last, a_err_valid;
   logic [31:0] a_out_data;
   logic [1:0]  a_err_code;
   logic        b_sig_ready, b_out_valid, b_out_first, b_out_last, b_err_valid;
   logic [31:0] b_out_data;
   logic [1:0]  b_err_code;
   logic        c_sig_ready, c_out_valid, c_out_first, c_out_last, c_err_valid;
   logic [7:0]  c_out_data;
   logic [1:0]  c_err_code;

   logic        m_sig_ready, m_valid, m_first, m_last, m_err_valid;
   logic [31:0] m_data;
   logic [1:0]  m_err_code;

   always #5 clk = ~clk;

   sig_word_serializer #(.WORD_W(32), .CHECK_RANGE(1'b1)) u_dut_a (
      .clk(clk), .rst_n(rst_n),
      .i_sig_valid(sig_valid && (sel == 0)), .o_sig_ready(a_sig_ready), .i_sig(sig),
      .o_out_valid(a_out_valid), .i_out_ready(out_ready), .o_out_data(a_out_data),
      .o_out_first(a_out_first), .o_out_last(a_out_last),
      .o_err_valid(a_err_valid), .o_err_code(a_err_code));

   sig_word_serializer #(.WORD_W(32), .CHECK_RANGE(1'b0)) u_dut_b (
      .clk(clk), .rst_n(rst_n),
      .i_sig_valid(sig_valid && (sel == 1)), .o_sig_ready(b_sig_ready), .i_sig(sig),
      .o_out_valid(b_out_valid), .i_out_ready(out_ready), .o_out_data(b_out_data),
      .o_out_first(b_out_first), .o_out_last(b_out_last),
      .o_err_valid(b_err_valid), .o_err_code(b_err_code));

   sig_word_serializer #(.WORD_W(8), .CHECK_RANGE(1'b1)) u_dut_c (
      .clk(clk), .rst_n(rst_n),
      .i_sig_valid(sig_valid && (sel == 2)), .o_sig_ready(c_sig_ready), .i_sig(sig),
      .o_out_valid(c_out_valid), .i_out_ready(out_ready), .o_out_data(c_out_data),
      .o_out_first(c_out_first), .o_out_last(c_out_last),
      .o_err_valid(c_err_valid), .o_err_code(c_err_code));

   always_comb begin
      m_sig_ready = a_sig_ready; m_valid = a_out_valid; m_first = a_out_first;
      m_last = a_out_last; m_err_valid = a_err_valid; m_err_code = a_err_code;
      m_data = a_out_data;
      if (sel == 1) begin
         m_sig_ready = b_sig_ready; m_valid = b_out_valid; m_first = b_out_first;
         m_last = b_out_last; m_err_valid = b_err_valid; m_err_code = b_err_code;
         m_data = b_out_data;
      end else if (sel == 2) begin
         m_sig_ready = c_sig_ready; m_valid = c_out_valid; m_first = c_out_first;
         m_last = c_out_last; m_err_valid = c_err_valid; m_err_code = c_err_code;
         m_data = {24'd0, c_out_data};
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h (sel=%0d t=%0t)", tag, obs, exp, sel, $time);
      end
   endtask

   function automatic bit is_bad(input logic [255:0] v);
      return (v == 256'd0) || (v >= c_N);
   endfunction

   // Word k of the big-endian stream is the k-th WORD_W chunk counted from the top.
   function automatic logic [31:0] exp_word(input logic [511:0] sg, input int w, input int k);
      logic [511:0] t;
      t = sg >> (512 - (k + 1) * w);
      if (w == 8) return {24'd0, t[7:0]};
      return t[31:0];
   endfunction

   function automatic logic [255:0] rnd256();
      logic [255:0] v = '0;
      for (int i = 0; i < 8; i++) v = {v[223:0], 32'($urandom())};
      return v;
   endfunction

   function automatic logic [255:0] rnd_half();
      case ($urandom_range(5))
         0:       return 256'd0;
         1:       return c_N + 256'($urandom_range(3));
         2:       return c_N - 256'd1;
         default: return rnd256();
      endcase
   endfunction

   task automatic check_reset_outputs(input string tag);
      check({tag, "_rdy"},   m_sig_ready, 1);
      check({tag, "_vld"},   m_valid, 0);
      check({tag, "_first"}, m_first, 0);
      check({tag, "_last"},  m_last, 0);
      check({tag, "_data"},  m_data, 0);
      check({tag, "_errv"},  m_err_valid, 0);
      check({tag, "_code"},  m_err_code, 0);
   endtask

   // Called at a negedge; returns at a negedge. abort>0 stops after that many beats.
   task automatic run(input int s, input logic [511:0] sg, input int stall, input int abort);
      int          w, nw, beat, cyc, limit;
      bit          rej, stalled;
      logic [1:0]  code;
      logic [31:0] prev;
      w     = (s == 2) ? 8 : 32;
      nw    = 512 / w;
      code  = {is_bad(sg[255:0]), is_bad(sg[511:256])};
      rej   = (s != 1) && (code != 2'b00);
      sel   = s;
      limit = nw * 40 + 20;
      #1;
      check("idle_rdy", m_sig_ready, 1);
      check("idle_vld", m_valid, 0);
      sig       = sg;
      sig_valid = 1'b1;
      out_ready = 1'($urandom_range(1));
      @(negedge clk);
      sig_valid = 1'b0;
      if (rej) begin
         check("rej_errv", m_err_valid, 1);
         check("rej_code", m_err_code, code);
         check("rej_vld",  m_valid, 0);
         check("rej_rdy",  m_sig_ready, 0);
         @(negedge clk);
         check("rej_pulse", m_err_valid, 0);
         check("rej_hold",  m_err_code, code);
         check("rej_vld2",  m_valid, 0);
         check("rej_back",  m_sig_ready, 1);
         return;
      end
      beat = 0; cyc = 0; stalled = 0; prev = '0;
      while (beat < nw && cyc < limit) begin
         if (abort > 0 && beat == abort) begin
            out_ready = 1'b0;
            return;
         end
         check("vld",   m_valid, 1);
         check("busy",  m_sig_ready, 0);
         check("noerr", m_err_valid, 0);
         check("data",  m_data, exp_word(sg, w, beat));
         check("first", m_first, beat == 0);
         check("last",  m_last, beat == nw - 1);
         if (stalled) check("stable", m_data, prev);
         prev      = m_data;
         out_ready = ($urandom_range(99) >= stall);
         if (out_ready) begin
            beat++;
            stalled = 0;
         end else begin
            stalled = 1;
         end
         @(negedge clk);
         cyc++;
      end
      check("beats", beat, nw);
      if (stall == 0) check("contig", cyc, nw);
      check("done_vld", m_valid, 0);
      check("done_rdy", m_sig_ready, 1);
      check("done_err", m_err_valid, 0);
      out_ready = 1'b0;
   endtask

   initial begin
      logic [511:0] pat;
      repeat (3) @(negedge clk);
      #1;
      check_reset_outputs("rst");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      run(0, {256'd1, 256'd2}, 0, 0);
      run(0, {c_N - 256'd1, c_N - 256'd1}, 50, 0);
      run(0, {256'd0, 256'd5}, 0, 0);
      run(0, {256'd3, c_N}, 0, 0);
      run(0, {c_N, c_N}, 0, 0);
      for (int i = 0; i < 8; i++) run(0, {rnd_half(), rnd_half()}, 40, 0);

      run(1, {256'd0, c_N}, 0, 0);
      for (int i = 0; i < 3; i++) run(1, {rnd_half(), rnd_half()}, 30, 0);

      // Abort a stream mid-flight with an asynchronous reset.
      run(0, {256'd7, 256'd9}, 0, 5);
      #3;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("abort");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run(0, {256'hA, 256'hB}, 0, 0);

      pat = '0;
      for (int k = 0; k < 64; k++) pat = {pat[503:0], 8'(k + 1)};
      run(2, pat, 0, 0);
      for (int i = 0; i < 3; i++) run(2, {rnd_half(), rnd_half()}, 50, 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
